// File: rtl/stage_memory_if.sv
// Bundle between the compute stage, the memory stage, the data-memory bus and the writeback path.
// Compute-stage control structs are flattened into plain fields.
interface stage_memory_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_mem_w_enable;
    logic [1:0]  in_mem_width;          // 0 byte, 1 half, 2 word
    logic        in_mem_r_sign_extend;
    logic [31:0] in_mem_w_value;
    logic        in_rd_enable;
    logic [4:0]  in_rd_which_register;
    logic [1:0]  in_rd_source;          // 1 = write from memory

    logic        dmem_req;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    logic        wb_enable;
    logic [4:0]  wb_which_register;
    logic [31:0] wb_value;
    logic        misaligned_fault;
    logic [31:0] fault_addr;

    modport master (
        output in_valid, in_result, in_mem_w_enable, in_mem_width, in_mem_r_sign_extend,
               in_mem_w_value, in_rd_enable, in_rd_which_register, in_rd_source,
               dmem_gnt, dmem_rvalid, dmem_rdata,
        input  in_ready, dmem_req, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata,
               wb_enable, wb_which_register, wb_value, misaligned_fault, fault_addr
    );

    modport slave (
        input  in_valid, in_result, in_mem_w_enable, in_mem_width, in_mem_r_sign_extend,
               in_mem_w_value, in_rd_enable, in_rd_which_register, in_rd_source,
               dmem_gnt, dmem_rvalid, dmem_rdata,
        output in_ready, dmem_req, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata,
               wb_enable, wb_which_register, wb_value, misaligned_fault, fault_addr
    );
endinterface

// File: rtl/stage_memory.sv
// Memory pipeline stage: ALU pass-through, loads/stores over a req/gnt/rvalid bus,
// registered writeback and a misaligned-access fault pulse.
module stage_memory (
    input  logic          i_clk,
    input  logic          i_rst,
    stage_memory_if.slave bus
);
    localparam logic [1:0] WidthByte  = 2'd0;
    localparam logic [1:0] WidthHalf  = 2'd1;
    localparam logic [1:0] RegFromMem = 2'd1;

    typedef enum logic [1:0] {StIdle, StReq, StWaitR} state_t;

    state_t      r_state;
    logic        r_req;
    logic [31:0] r_addr;
    logic        r_we;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic [1:0]  r_off;
    logic [1:0]  r_width;
    logic        r_sign;
    logic        r_ld_wb;
    logic [4:0]  r_rd;
    logic        r_wb_enable;
    logic [4:0]  r_wb_reg;
    logic [31:0] r_wb_value;
    logic        r_fault;
    logic [31:0] r_fault_addr;

    logic        w_is_store;
    logic        w_is_mem;
    logic        w_misaligned;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [31:0] w_load_value;

    always_comb begin
        w_is_store = bus.in_mem_w_enable;
        w_is_mem   = w_is_store || (bus.in_rd_enable && bus.in_rd_source == RegFromMem);
        unique case (bus.in_mem_width)
            WidthByte: w_misaligned = 1'b0;
            WidthHalf: w_misaligned = bus.in_result[0];
            default:   w_misaligned = (bus.in_result[1:0] != 2'b00);
        endcase
    end

    // Store lanes are replicated so the strobe alone selects the bytes written.
    always_comb begin
        unique case (bus.in_mem_width)
            WidthByte: begin
                w_wdata = {4{bus.in_mem_w_value[7:0]}};
                w_strb  = 4'b0001 << bus.in_result[1:0];
            end
            WidthHalf: begin
                w_wdata = {2{bus.in_mem_w_value[15:0]}};
                w_strb  = 4'b0011 << bus.in_result[1:0];
            end
            default: begin
                w_wdata = bus.in_mem_w_value;
                w_strb  = 4'b1111;
            end
        endcase
    end

    always_comb begin
        w_shift = bus.dmem_rdata >> {r_off, 3'b000};
        unique case (r_width)
            WidthByte: w_load_value = {{24{r_sign & w_shift[7]}}, w_shift[7:0]};
            WidthHalf: w_load_value = {{16{r_sign & w_shift[15]}}, w_shift[15:0]};
            default:   w_load_value = w_shift;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_req        <= 1'b0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wstrb      <= '0;
            r_wdata      <= '0;
            r_off        <= '0;
            r_width      <= '0;
            r_sign       <= 1'b0;
            r_ld_wb      <= 1'b0;
            r_rd         <= '0;
            r_wb_enable  <= 1'b0;
            r_wb_reg     <= '0;
            r_wb_value   <= '0;
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
        end else begin
            r_wb_enable <= 1'b0;
            r_fault     <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.in_valid) begin
                        if (w_is_mem && w_misaligned) begin
                            r_fault      <= 1'b1;
                            r_fault_addr <= bus.in_result;
                        end else if (w_is_mem) begin
                            r_req   <= 1'b1;
                            r_addr  <= {bus.in_result[31:2], 2'b00};
                            r_off   <= bus.in_result[1:0];
                            r_width <= bus.in_mem_width;
                            r_sign  <= bus.in_mem_r_sign_extend;
                            r_we    <= w_is_store;
                            r_wstrb <= w_is_store ? w_strb : 4'b0000;
                            r_wdata <= w_is_store ? w_wdata : 32'h0;
                            r_rd    <= bus.in_rd_which_register;
                            // Stores never write back; x0 is never written.
                            r_ld_wb <= !w_is_store && (bus.in_rd_which_register != 5'd0);
                            r_state <= StReq;
                        end else if (bus.in_rd_enable && bus.in_rd_which_register != 5'd0) begin
                            r_wb_enable <= 1'b1;
                            r_wb_reg    <= bus.in_rd_which_register;
                            r_wb_value  <= bus.in_result;
                        end
                    end
                end
                StReq: begin
                    if (bus.dmem_gnt) begin
                        r_req   <= 1'b0;
                        r_state <= r_we ? StIdle : StWaitR;
                    end
                end
                StWaitR: begin
                    if (bus.dmem_rvalid) begin
                        r_wb_enable <= r_ld_wb;
                        r_wb_reg    <= r_rd;
                        r_wb_value  <= w_load_value;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.in_ready          = (r_state == StIdle);
    assign bus.dmem_req          = r_req;
    assign bus.dmem_addr         = r_addr;
    assign bus.dmem_we           = r_we;
    assign bus.dmem_wstrb        = r_wstrb;
    assign bus.dmem_wdata        = r_wdata;
    assign bus.wb_enable         = r_wb_enable;
    assign bus.wb_which_register = r_wb_reg;
    assign bus.wb_value          = r_wb_value;
    assign bus.misaligned_fault  = r_fault;
    assign bus.fault_addr        = r_fault_addr;
endmodule

// File: tb/tb_stage_memory.sv
// Directed bench for stage_memory: inputs driven on the falling edge, outputs checked on the
// following falling edge against hand-computed values.
module tb_stage_memory;
    localparam logic [1:0] WB = 2'd0;
    localparam logic [1:0] WH = 2'd1;
    localparam logic [1:0] WW = 2'd2;
    localparam logic [1:0] SrcAlu = 2'd0;
    localparam logic [1:0] SrcMem = 2'd1;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;

    stage_memory_if bus ();

    stage_memory dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic [31:0] res, input logic we,
                         input logic [1:0] width, input logic sign, input logic [31:0] wval,
                         input logic rd_en, input logic [4:0] rd, input logic [1:0] src);
        bus.in_valid             = valid;
        bus.in_result            = res;
        bus.in_mem_w_enable      = we;
        bus.in_mem_width         = width;
        bus.in_mem_r_sign_extend = sign;
        bus.in_mem_w_value       = wval;
        bus.in_rd_enable         = rd_en;
        bus.in_rd_which_register = rd;
        bus.in_rd_source         = src;
    endtask

    task automatic idle_in();
        drive(1'b0, 32'h0, 1'b0, WB, 1'b0, 32'h0, 1'b0, 5'd0, SrcAlu);
    endtask

    // Store with immediate grant; checks lanes in REQ and return to IDLE after the grant.
    task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] width,
                            input logic [31:0] val, input logic [3:0] strb,
                            input logic [31:0] data);
        drive(1'b1, addr, 1'b1, width, 1'b0, val, 1'b0, 5'd0, SrcAlu);
        tick();
        idle_in();
        check({tag, "_req"}, bus.dmem_req, 1);
        check({tag, "_addr"}, bus.dmem_addr, {addr[31:2], 2'b00});
        check({tag, "_strb"}, bus.dmem_wstrb, strb);
        check({tag, "_data"}, bus.dmem_wdata, data);
        bus.dmem_gnt = 1'b1;
        tick();
        bus.dmem_gnt = 1'b0;
        check({tag, "_ready"}, bus.in_ready, 1);
        check({tag, "_nowb"}, bus.wb_enable, 0);
    endtask

    // Load with grant one cycle after request and rvalid one cycle after grant.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] width,
                           input logic sign, input logic [4:0] rd, input logic [31:0] rdata,
                           input logic exp_en, input logic [31:0] exp_val);
        drive(1'b1, addr, 1'b0, width, sign, 32'h0, 1'b1, rd, SrcMem);
        tick();
        idle_in();
        check({tag, "_req"}, bus.dmem_req, 1);
        check({tag, "_we"}, bus.dmem_we, 0);
        check({tag, "_addr"}, bus.dmem_addr, {addr[31:2], 2'b00});
        bus.dmem_gnt = 1'b1;
        tick();
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = rdata;
        check({tag, "_waitreq"}, bus.dmem_req, 0);
        check({tag, "_waitrdy"}, bus.in_ready, 0);
        tick();
        bus.dmem_rvalid = 1'b0;
        check({tag, "_wben"}, bus.wb_enable, exp_en);
        if (exp_en) begin
            check({tag, "_wbval"}, bus.wb_value, exp_val);
            check({tag, "_wbreg"}, bus.wb_which_register, rd);
        end
        check({tag, "_ready"}, bus.in_ready, 1);
        tick();
        check({tag, "_wbpulse"}, bus.wb_enable, 0);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b1;
        idle_in();
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = 32'h0;
        repeat (2) tick();

        check("rst_ready", bus.in_ready, 1);
        check("rst_req", bus.dmem_req, 0);
        check("rst_wb", bus.wb_enable, 0);
        check("rst_wbval", bus.wb_value, 0);
        check("rst_fault", bus.misaligned_fault, 0);
        check("rst_addr", bus.dmem_addr, 0);
        rst = 1'b0;

        // ALU pass-through, back to back.
        drive(1'b1, 32'h11, 1'b0, WW, 1'b0, 32'h0, 1'b1, 5'd5, SrcAlu);
        tick();
        check("alu0_en", bus.wb_enable, 1);
        check("alu0_val", bus.wb_value, 32'h11);
        check("alu0_reg", bus.wb_which_register, 5);
        drive(1'b1, 32'h22, 1'b0, WW, 1'b0, 32'h0, 1'b1, 5'd6, SrcAlu);
        tick();
        check("alu1_en", bus.wb_enable, 1);
        check("alu1_val", bus.wb_value, 32'h22);
        check("alu1_reg", bus.wb_which_register, 6);
        drive(1'b1, 32'h33, 1'b0, WW, 1'b0, 32'h0, 1'b1, 5'd7, SrcAlu);
        tick();
        idle_in();
        check("alu2_en", bus.wb_enable, 1);
        check("alu2_val", bus.wb_value, 32'h33);
        check("alu2_reg", bus.wb_which_register, 7);
        check("alu_req", bus.dmem_req, 0);
        tick();
        check("alu_end", bus.wb_enable, 0);

        // Store byte, grant delayed three cycles.
        drive(1'b1, 32'h1003, 1'b1, WB, 1'b0, 32'hA5, 1'b0, 5'd0, SrcAlu);
        for (int i = 0; i < 3; i++) begin
            tick();
            idle_in();
            check("stb_req", bus.dmem_req, 1);
            check("stb_ready", bus.in_ready, 0);
            check("stb_addr", bus.dmem_addr, 32'h1000);
            check("stb_we", bus.dmem_we, 1);
            check("stb_strb", bus.dmem_wstrb, 4'b1000);
            check("stb_data", bus.dmem_wdata, 32'hA5A5A5A5);
        end
        bus.dmem_gnt = 1'b1;
        tick();
        bus.dmem_gnt = 1'b0;
        check("stb_done_req", bus.dmem_req, 0);
        check("stb_done_ready", bus.in_ready, 1);
        check("stb_nowb", bus.wb_enable, 0);

        do_store("sth", 32'h6002, WH, 32'h1234BEEF, 4'b1100, 32'hBEEFBEEF);
        do_store("stw", 32'h7000, WW, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);

        // Load half signed, rvalid two cycles after grant.
        drive(1'b1, 32'h2002, 1'b0, WH, 1'b1, 32'h0, 1'b1, 5'd9, SrcMem);
        tick();
        idle_in();
        check("lhs_req", bus.dmem_req, 1);
        check("lhs_addr", bus.dmem_addr, 32'h2000);
        check("lhs_strb", bus.dmem_wstrb, 0);
        bus.dmem_gnt = 1'b1;
        tick();
        bus.dmem_gnt = 1'b0;
        tick();
        check("lhs_wait_wb", bus.wb_enable, 0);
        check("lhs_wait_rdy", bus.in_ready, 0);
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h80017FFF;
        tick();
        bus.dmem_rvalid = 1'b0;
        check("lhs_en", bus.wb_enable, 1);
        check("lhs_val", bus.wb_value, 32'hFFFF8001);
        check("lhs_reg", bus.wb_which_register, 9);
        tick();
        check("lhs_pulse", bus.wb_enable, 0);

        do_load("lhu", 32'h2002, WH, 1'b0, 5'd10, 32'h80017FFF, 1'b1, 32'h00008001);
        do_load("lbs", 32'h8001, WB, 1'b1, 5'd11, 32'h11228344, 1'b1, 32'hFFFFFF83);
        do_load("lbu", 32'h8003, WB, 1'b0, 5'd12, 32'hF0228344, 1'b1, 32'h000000F0);
        do_load("lw", 32'h8000, WW, 1'b1, 5'd13, 32'h89ABCDEF, 1'b1, 32'h89ABCDEF);
        do_load("lx0", 32'h4000, WW, 1'b0, 5'd0, 32'hDEADBEEF, 1'b0, 32'h0);

        // Misaligned word load.
        drive(1'b1, 32'h3001, 1'b0, WW, 1'b0, 32'h0, 1'b1, 5'd3, SrcMem);
        tick();
        idle_in();
        check("mis_fault", bus.misaligned_fault, 1);
        check("mis_addr", bus.fault_addr, 32'h3001);
        check("mis_req", bus.dmem_req, 0);
        check("mis_wb", bus.wb_enable, 0);
        check("mis_ready", bus.in_ready, 1);
        tick();
        check("mis_pulse", bus.misaligned_fault, 0);
        check("mis_req2", bus.dmem_req, 0);

        // Misaligned half store.
        drive(1'b1, 32'h3003, 1'b1, WH, 1'b0, 32'h55, 1'b0, 5'd0, SrcAlu);
        tick();
        idle_in();
        check("mish_fault", bus.misaligned_fault, 1);
        check("mish_addr", bus.fault_addr, 32'h3003);
        check("mish_req", bus.dmem_req, 0);

        // Reset asserted in WAIT_R.
        tick();
        drive(1'b1, 32'h5004, 1'b0, WW, 1'b0, 32'h0, 1'b1, 5'd4, SrcMem);
        tick();
        idle_in();
        bus.dmem_gnt = 1'b1;
        tick();
        bus.dmem_gnt = 1'b0;
        check("rw_ready", bus.in_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("rw_rst_ready", bus.in_ready, 1);
        check("rw_rst_req", bus.dmem_req, 0);
        check("rw_rst_wb", bus.wb_enable, 0);
        tick();
        rst = 1'b0;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h12345678;
        tick();
        bus.dmem_rvalid = 1'b0;
        check("rw_late_wb", bus.wb_enable, 0);
        check("rw_late_ready", bus.in_ready, 1);
        check("rw_late_fault", bus.misaligned_fault, 0);

        // Reset asserted in REQ drops the request immediately.
        drive(1'b1, 32'h9000, 1'b1, WW, 1'b0, 32'h1, 1'b0, 5'd0, SrcAlu);
        tick();
        idle_in();
        check("rq_req", bus.dmem_req, 1);
        #2 rst = 1'b1;
        #1;
        check("rq_rst_req", bus.dmem_req, 0);
        check("rq_rst_strb", bus.dmem_wstrb, 0);
        tick();
        rst = 1'b0;
        tick();
        check("rq_after_ready", bus.in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
